serial_result_collector: RTL

- Downstream consumer of the adder datapath's parallel-in/serial-out stage.
- Takes its bit stream plus the start-of-frame strobe, reassembles WIDTH-bit result words and buffers them in a small FIFO.
- Presents buffered words on a valid/ready interface to the next consumer (register file / write-back logic).
- Flags dropped words and aborted frames.

---
 rtl/serial_result_collector_pkg.sv | 18 +
 rtl/result_fifo.sv | 70 +++++++
 rtl/serial_result_collector.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// serial_result_collector_pkg
// Definitions shared between the adder datapath's serial output stage and
// the result collector that reassembles its frames.
//   DEFAULT_WIDTH    : bits per serial frame / result word
//   collectorState_t : receive FSM states (IDLE, SHIFT, PUSH)
// ---------------------------------------------------------------------------
package serial_result_collector_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } collectorState_t;

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO buffering reassembled result words.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write wrData this cycle (accepted if not full, or if full
//                and a pop happens in the same cycle)
//   pop        : remove the head word (ignored while empty)
//   wrData     : word to write
//   rdData     : head word, forced to zero while empty
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             pushOk;
    logic             popOk;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    // A full FIFO still takes a word when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign pushOk = push & (~full | pop);
    assign popOk  = pop & ~empty;
    assign rdData = empty ? '0 : mem[rdPtr];

    // NOTE: storage has no reset; emptiness is tracked by count and the read
    // port is masked while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            unique case ({pushOk, popOk})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_result_collector.sv
// ---------------------------------------------------------------------------
// serial_result_collector
// Reassembles WIDTH-bit words from the adder's serial output stream, buffers
// them in a small FIFO and offers them on a valid/ready interface.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   serial_in    : one data bit per cycle while a frame is active
//   frame_start  : high together with bit 0 of a frame
//   out_data     : FIFO head word
//   out_valid    : FIFO non-empty
//   out_ready    : consumer takes out_data when out_valid & out_ready
//   fifo_count   : FIFO occupancy
//   busy         : a frame is being shifted in or pushed
//   overflow     : sticky, a completed word was dropped on a full FIFO
//   frame_err    : sticky, a frame was cut short by an early frame_start
//   clear_flags  : clears both sticky flags; a same-cycle set wins
// ---------------------------------------------------------------------------
module serial_result_collector
    import serial_result_collector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       serial_in,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clear_flags
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  FIRST_DONE = CNT_W'(1);

    collectorState_t  state;
    collectorState_t  stateNext;
    logic [CNT_W-1:0] bitCount;
    logic [CNT_W-1:0] countNext;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] wordNext;
    logic             pushReq;
    logic             abortFrame;
    logic             popReq;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             dropWord;

    // Writes bit b into the word position of serial bit k. The loop keeps
    // every index constant so no dynamic part-select is needed.
    function automatic logic [WIDTH-1:0] placeBit(
        input logic [WIDTH-1:0] word,
        input logic [CNT_W-1:0] k,
        input logic             b
    );
        logic [WIDTH-1:0] result;
        result = word;
        for (int i = 0; i < WIDTH; i++) begin
            if (( LSB_FIRST && i == int'(k)) ||
                (!LSB_FIRST && i == WIDTH - 1 - int'(k))) begin
                result[i] = b;
            end
        end
        return result;
    endfunction

    assign out_valid = ~fifoEmpty;
    assign popReq    = out_valid & out_ready;
    assign busy      = (state != IDLE);
    assign dropWord  = pushReq & fifoFull & ~popReq;

    // NOTE: every signal gets a default before the case so that paths which
    // leave it untouched hold the default rather than inferring a latch.
    always_comb begin
        stateNext  = state;
        countNext  = bitCount;
        wordNext   = shiftReg;
        pushReq    = 1'b0;
        abortFrame = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    wordNext  = placeBit('0, '0, serial_in);
                    countNext = FIRST_DONE;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    // Early start: throw away the partial word and restart.
                    abortFrame = 1'b1;
                    wordNext   = placeBit('0, '0, serial_in);
                    countNext  = FIRST_DONE;
                end else begin
                    wordNext = placeBit(shiftReg, bitCount, serial_in);
                    if (bitCount == LAST_BIT) begin
                        countNext = '0;
                        stateNext = PUSH;
                    end else begin
                        countNext = bitCount + CNT_W'(1);
                    end
                end
            end
            PUSH: begin
                // shiftReg holds the finished word this cycle; a new frame
                // may start now and overwrite it at the edge.
                pushReq = 1'b1;
                if (frame_start) begin
                    wordNext  = placeBit('0, '0, serial_in);
                    countNext = FIRST_DONE;
                    stateNext = SHIFT;
                end else begin
                    countNext = '0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all registered state so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitCount  <= '0;
            shiftReg  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCount  <= countNext;
            shiftReg  <= wordNext;
            overflow  <= (overflow  & ~clear_flags) | dropWord;
            frame_err <= (frame_err & ~clear_flags) | abortFrame;
        end
    end

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (pushReq),
        .pop    (popReq),
        .wrData (shiftReg),
        .rdData (out_data),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifo_count)
    );

endmodule
